daq_packetizer: RTL and testbench
=================================

# daq_packetizer

Framing stage that sits directly upstream of the AXI-stream FIFO in the acquisition path. It takes a free-running ADC sample strobe, which has no backpressure, and builds AXI-stream packets: one header beat, then `PKT_LEN` payload beats, with `tlast` on the final beat. A one-entry pending register absorbs short stalls. Samples that still cannot be stored are dropped, counted, and flagged in the next header.

## Interface
- `DATA_W`, 32: output beat width. Must be ≥ 32.
- `USER_W`, 8: `tuser` width. Must be ≥ 2.
- `SAMPLE_W`, 16: ADC sample width. Must be ≤ `DATA_W`.
- `PKT_LEN`, 64: payload beats per packet. Range 1..65535.

Ports (clock and reset first):
- `clk`  in  1  single clock; everything is synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  arms packetization; sampled only at packet boundaries.
- `sample_valid`  in  1  one-cycle strobe per ADC sample; no ready is returned.
- `sample_data`  in  `SAMPLE_W`  sample value, qualified by `sample_valid`.
- `m_axi_if`  `axi_if.master`  output stream to the FIFO; carries `tvalid`, `tready`, `tdata[DATA_W]`, `tlast` and `tuser[USER_W]`.
- `drop_count`  out  16  samples dropped while armed; saturates at 16'hFFFF; cleared only by `rst`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `pop` = `tvalid && tready`. The output register can load a new beat when `!tvalid || pop`.
- Once `tvalid` is high, `tdata`, `tlast` and `tuser` hold stable until `pop`.
- **Header beat:**
  - `tdata` = {`seq[15:0]`, `PKT_LEN[15:0]`}, zero-extended to `DATA_W`.
  - `tuser[0]` = 1 (start of packet); `tuser[1]` = sticky drop flag; all other bits 0.
  - `tlast` = 0.
- **Payload beat:**
  - `tdata` = `sample_data`, zero-extended.
  - `tuser` = 0.
  - `tlast` = 1 only when `beat_cnt == PKT_LEN-1`.
- **States:**
  - IDLE: the output register is empty. When `enable` = 1, load the header and go to HDR.
  - HDR: the header is presented. On `pop`, go to PAY with `beat_cnt` = 0; a payload load can occur in the same cycle.
  - PAY: each load takes a source in priority order, pending register first, then the incoming sample, and increments `beat_cnt`. No loads occur after the last beat has been loaded.
  - Pop of the last beat: `seq` increments, wrapping at 16 bits. If `enable` = 1, load the next header in the same cycle and stay in HDR. Otherwise go to IDLE.
- **Sample routing while armed (HDR or PAY):**
  - An incoming sample goes to the output register if a payload load is allowed this cycle and the pending register is empty.
  - Otherwise it goes to the pending register if that register is empty.
  - Otherwise it is dropped: `drop_count` += 1 (saturating) and the drop flag is set.
  - A sample arriving while the last beat is waiting for `pop` follows the same pending/drop rule. Header loads never consume samples.
- **Drop flag:** cleared when a header loads. A drop in the same cycle as a header load sets the flag again, so it is reported in the following header.
- **IDLE:** samples are discarded silently; neither the counter nor the flag changes. Packets never contain a partial payload.
- **`enable` deasserted mid-packet:** the current packet completes normally, then the block goes to IDLE. Any pending sample is discarded on that IDLE entry.

## Timing
- Reset values: `tvalid` 0, `tdata` 0, `tlast` 0, `tuser` 0, `busy` 0, `drop_count` 0, `seq` 0, pending register empty, state IDLE.
- Asserting `rst` mid-packet clears all state asynchronously; `tvalid` drops immediately, with no clock edge needed.
- `enable` high at edge N in IDLE: header `tvalid` is high after edge N.
- Sample latency: `sample_valid` at edge N with the output register loadable gives `tvalid` with that sample after edge N, i.e. one cycle.
- With `tready` held at 1, throughput is one beat per clock.
- Pending depth is exactly 1: a stall of one cycle while another sample is held loses nothing.
- Back-to-back header and last beat: the header loads in the same cycle the last payload beat pops, so there is no bubble.

## Test plan
- **Basic packet:** `PKT_LEN`=4, `tready`=1, `enable`=1, samples 1..4 on consecutive cycles -> header `tdata`=0x00000004 with `tuser`=0x01, then beats 1,2,3,4 with `tlast` only on 4; second header carries `seq`=1.
- **Stall absorbed:** `tready`=0 for 1 cycle in mid-payload while samples arrive every cycle -> no drop, `drop_count`=0, payload order preserved.
- **Overflow:** `tready`=0 for 5 cycles with a sample each cycle -> `drop_count`=3, next header `tuser`=0x03, and the header after that `tuser`=0x01.
- **Saturation:** force 70000 drops -> `drop_count` = 0xFFFF and stays there.
- **Disable mid-packet:** drop `enable` at payload beat 2 of 4 -> packet finishes with `tlast`, no new header, `busy`=0; samples in IDLE are not counted.
- **Async reset mid-packet:** assert `rst` between edges -> `tvalid`=0 immediately. After release with `enable`=1, the header shows `seq`=0.

Source files
------------

// File: rtl/axi_if.sv
// AXI-stream beat interface between the packetizer and the downstream FIFO.
interface axi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/daq_packetizer.sv
// Frames a free-running ADC sample strobe into AXI-stream packets (header + PKT_LEN payload beats),
// with a one-entry pending register and saturating drop accounting.
module daq_packetizer #(
    parameter int DATA_W   = 32,
    parameter int USER_W   = 8,
    parameter int SAMPLE_W = 16,
    parameter int PKT_LEN  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    axi_if.master               m_axi_if,
    output logic [15:0]         drop_count,
    output logic                busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    localparam logic [15:0] PKT_LEN_W = 16'(PKT_LEN);
    localparam logic [15:0] LAST_IDX  = 16'(PKT_LEN - 1);

    logic [1:0]          state_q, state_d;
    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tlast_q, tlast_d;
    logic [USER_W-1:0]   tuser_q, tuser_d;
    logic [15:0]         seq_q, seq_d;
    logic [15:0]         beat_cnt_q, beat_cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [SAMPLE_W-1:0] pend_data_q, pend_data_d;
    logic                drop_flag_q, drop_flag_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic                pop, can_load, armed;
    logic                hdr_load, pay_ok, pay_load, go_idle;
    logic                pend_used, take_direct, to_pend, drop;
    logic [DATA_W-1:0]   hdr_word, pay_word;

    assign pop      = tvalid_q && m_axi_if.tready;
    assign can_load = !tvalid_q || pop;
    assign armed    = (state_q != ST_IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        hdr_load = 1'b0;
        pay_ok   = 1'b0;
        go_idle  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    hdr_load = 1'b1;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (pop) begin
                    state_d = ST_PAY;
                    pay_ok  = 1'b1;
                end
            end
            ST_PAY: begin
                // Once PKT_LEN beats are loaded, only the pop of the last one moves us on.
                pay_ok = can_load && (beat_cnt_q != PKT_LEN_W);
                if (pop && tlast_q) begin
                    seq_d = seq_q + 16'd1;
                    if (enable) begin
                        hdr_load = 1'b1;
                        state_d  = ST_HDR;
                    end else begin
                        go_idle = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pay_load  = pay_ok && (pend_valid_q || sample_valid);
        pend_used = pay_load && pend_valid_q;

        // A pending slot being drained this cycle can take the incoming sample.
        take_direct = armed && sample_valid && pay_ok && !pend_valid_q;
        to_pend     = armed && sample_valid && !take_direct && (!pend_valid_q || pend_used);
        drop        = armed && sample_valid && !take_direct && !to_pend;

        hdr_word        = '0;
        hdr_word[31:0]  = {seq_d, PKT_LEN_W};
        pay_word        = '0;
        pay_word[SAMPLE_W-1:0] = pend_valid_q ? pend_data_q : sample_data;

        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        beat_cnt_d = beat_cnt_q;
        if (hdr_load) begin
            tvalid_d   = 1'b1;
            tdata_d    = hdr_word;
            tlast_d    = 1'b0;
            tuser_d    = '0;
            tuser_d[0] = 1'b1;
            tuser_d[1] = drop_flag_q;
            beat_cnt_d = '0;
        end else if (pay_load) begin
            tvalid_d   = 1'b1;
            tdata_d    = pay_word;
            tlast_d    = (beat_cnt_q == LAST_IDX);
            tuser_d    = '0;
            beat_cnt_d = beat_cnt_q + 16'd1;
        end else if (pop) begin
            tvalid_d = 1'b0;
        end

        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (go_idle) begin
            pend_valid_d = 1'b0;
        end else if (to_pend) begin
            pend_valid_d = 1'b1;
            pend_data_d  = sample_data;
        end else if (pend_used) begin
            pend_valid_d = 1'b0;
        end

        // A drop coinciding with a header load is reported in the following header.
        drop_flag_d  = (hdr_load ? 1'b0 : drop_flag_q) | drop;
        drop_count_d = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            seq_q        <= '0;
            beat_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            drop_flag_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            seq_q        <= seq_d;
            beat_cnt_q   <= beat_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_axi_if.tvalid = tvalid_q;
    assign m_axi_if.tdata  = tdata_q;
    assign m_axi_if.tlast  = tlast_q;
    assign m_axi_if.tuser  = tuser_q;
    assign drop_count      = drop_count_q;
    assign busy            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_daq_packetizer.sv
// Directed bench for daq_packetizer with PKT_LEN=4: vector table for packet framing, stall, overflow
// and disable, plus hand-written async-reset and drop-counter saturation sequences.
module tb_daq_packetizer;
    localparam int DATA_W   = 32;
    localparam int USER_W   = 8;
    localparam int SAMPLE_W = 16;
    localparam int PKT_LEN  = 4;
    localparam int NVEC     = 36;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic [15:0]         drop_count;
    logic                busy;

    axi_if #(.DATA_W(DATA_W), .USER_W(USER_W)) axis ();

    daq_packetizer #(
        .DATA_W(DATA_W), .USER_W(USER_W), .SAMPLE_W(SAMPLE_W), .PKT_LEN(PKT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .m_axi_if     (axis.master),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sv;
        logic [15:0] sd;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic [7:0]  e_user;
        logic        e_busy;
        logic [15:0] e_dcnt;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic sv, input logic [15:0] sd, input logic rdy,
                                input logic ev, input logic [31:0] ed, input logic el,
                                input logic [7:0] eu, input logic eb, input logic [15:0] ec);
        vec_t v;
        v.en = en; v.sv = sv; v.sd = sd; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_user = eu; v.e_busy = eb; v.e_dcnt = ec;
        return v;
    endfunction

    initial begin
        // Basic packet, then second header with seq=1
        vecs[0]  = mk(1, 0, 16'h0,  1, 1, 32'h0000_0004, 0, 8'h01, 1, 0);
        vecs[1]  = mk(1, 1, 16'h1,  1, 1, 32'h1,         0, 8'h00, 1, 0);
        vecs[2]  = mk(1, 1, 16'h2,  1, 1, 32'h2,         0, 8'h00, 1, 0);
        vecs[3]  = mk(1, 1, 16'h3,  1, 1, 32'h3,         0, 8'h00, 1, 0);
        vecs[4]  = mk(1, 1, 16'h4,  1, 1, 32'h4,         1, 8'h00, 1, 0);
        vecs[5]  = mk(1, 0, 16'h0,  1, 1, 32'h0001_0004, 0, 8'h01, 1, 0);
        // One-cycle stall absorbed by the pending register
        vecs[6]  = mk(1, 1, 16'h10, 1, 1, 32'h10,        0, 8'h00, 1, 0);
        vecs[7]  = mk(1, 1, 16'h11, 0, 1, 32'h10,        0, 8'h00, 1, 0);
        vecs[8]  = mk(1, 1, 16'h12, 1, 1, 32'h11,        0, 8'h00, 1, 0);
        vecs[9]  = mk(1, 1, 16'h13, 1, 1, 32'h12,        0, 8'h00, 1, 0);
        vecs[10] = mk(1, 0, 16'h0,  1, 1, 32'h13,        1, 8'h00, 1, 0);
        vecs[11] = mk(1, 0, 16'h0,  1, 1, 32'h0002_0004, 0, 8'h01, 1, 0);
        // Output empties, then 5-cycle stall with a sample every cycle: 1 out, 1 pending, 3 drops
        vecs[12] = mk(1, 1, 16'h20, 1, 1, 32'h20,        0, 8'h00, 1, 0);
        vecs[13] = mk(1, 0, 16'h0,  1, 0, 32'h0,         0, 8'h00, 1, 0);
        vecs[14] = mk(1, 1, 16'h21, 0, 1, 32'h21,        0, 8'h00, 1, 0);
        vecs[15] = mk(1, 1, 16'h22, 0, 1, 32'h21,        0, 8'h00, 1, 0);
        vecs[16] = mk(1, 1, 16'h23, 0, 1, 32'h21,        0, 8'h00, 1, 1);
        vecs[17] = mk(1, 1, 16'h24, 0, 1, 32'h21,        0, 8'h00, 1, 2);
        vecs[18] = mk(1, 1, 16'h25, 0, 1, 32'h21,        0, 8'h00, 1, 3);
        vecs[19] = mk(1, 0, 16'h0,  1, 1, 32'h22,        0, 8'h00, 1, 3);
        vecs[20] = mk(1, 1, 16'h26, 1, 1, 32'h26,        1, 8'h00, 1, 3);
        vecs[21] = mk(1, 0, 16'h0,  1, 1, 32'h0003_0004, 0, 8'h03, 1, 3);
        vecs[22] = mk(1, 1, 16'h30, 1, 1, 32'h30,        0, 8'h00, 1, 3);
        vecs[23] = mk(1, 1, 16'h31, 1, 1, 32'h31,        0, 8'h00, 1, 3);
        vecs[24] = mk(1, 1, 16'h32, 1, 1, 32'h32,        0, 8'h00, 1, 3);
        vecs[25] = mk(1, 1, 16'h33, 1, 1, 32'h33,        1, 8'h00, 1, 3);
        vecs[26] = mk(1, 0, 16'h0,  1, 1, 32'h0004_0004, 0, 8'h01, 1, 3);
        // Enable dropped at payload beat 2: packet completes, IDLE, samples ignored
        vecs[27] = mk(1, 1, 16'h40, 1, 1, 32'h40,        0, 8'h00, 1, 3);
        vecs[28] = mk(0, 1, 16'h41, 1, 1, 32'h41,        0, 8'h00, 1, 3);
        vecs[29] = mk(0, 1, 16'h42, 1, 1, 32'h42,        0, 8'h00, 1, 3);
        vecs[30] = mk(0, 1, 16'h43, 1, 1, 32'h43,        1, 8'h00, 1, 3);
        vecs[31] = mk(0, 0, 16'h0,  1, 0, 32'h0,         0, 8'h00, 0, 3);
        vecs[32] = mk(0, 1, 16'h50, 1, 0, 32'h0,         0, 8'h00, 0, 3);
        vecs[33] = mk(0, 1, 16'h51, 1, 0, 32'h0,         0, 8'h00, 0, 3);
        vecs[34] = mk(1, 0, 16'h0,  1, 1, 32'h0005_0004, 0, 8'h01, 1, 3);
        vecs[35] = mk(1, 1, 16'h60, 1, 1, 32'h60,        0, 8'h00, 1, 3);

        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        axis.tready  = 1'b0;

        repeat (2) step();
        check("rst tvalid", 32'(axis.tvalid), 32'h0);
        check("rst tdata",  axis.tdata,       32'h0);
        check("rst tlast",  32'(axis.tlast),  32'h0);
        check("rst tuser",  32'(axis.tuser),  32'h0);
        check("rst busy",   32'(busy),        32'h0);
        check("rst dcnt",   32'(drop_count),  32'h0);
        rst = 1'b0;
        step();
        check("idle tvalid", 32'(axis.tvalid), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            enable       = vecs[i].en;
            sample_valid = vecs[i].sv;
            sample_data  = vecs[i].sd;
            axis.tready  = vecs[i].rdy;
            step();
            check($sformatf("v%0d tvalid", i), 32'(axis.tvalid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d busy", i),   32'(busy),        32'(vecs[i].e_busy));
            check($sformatf("v%0d dcnt", i),   32'(drop_count),  32'(vecs[i].e_dcnt));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d tdata", i), axis.tdata,       vecs[i].e_data);
                check($sformatf("v%0d tlast", i), 32'(axis.tlast),  32'(vecs[i].e_last));
                check($sformatf("v%0d tuser", i), 32'(axis.tuser),  32'(vecs[i].e_user));
            end
        end

        // Async reset between edges: outputs clear with no clock edge
        #2;
        rst = 1'b1;
        #1;
        check("async tvalid", 32'(axis.tvalid), 32'h0);
        check("async busy",   32'(busy),        32'h0);
        check("async dcnt",   32'(drop_count),  32'h0);
        step();
        rst          = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        axis.tready  = 1'b1;
        step();
        check("post-rst hdr tvalid", 32'(axis.tvalid), 32'h1);
        check("post-rst hdr tdata",  axis.tdata,       32'h0000_0004);
        check("post-rst hdr tuser",  32'(axis.tuser),  32'h01);

        // Saturation: header stalled, first sample parks in pending, every later one drops
        axis.tready  = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 16'hABCD;
        step();
        check("sat pending dcnt", 32'(drop_count), 32'h0);
        repeat (65534) step();
        check("sat pre dcnt", 32'(drop_count), 32'hFFFE);
        step();
        check("sat hit dcnt", 32'(drop_count), 32'hFFFF);
        repeat (70000 - 65535) step();
        check("sat hold dcnt",  32'(drop_count), 32'hFFFF);
        check("sat hdr tvalid", 32'(axis.tvalid), 32'h1);
        check("sat hdr tdata",  axis.tdata,       32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
